uart_byte_rx: RTL and testbench
===============================

# uart_byte_rx

Serial receive front end for the switchboard traffic controller. Turns the asynchronous `serialIn` line (8N1, LSB first, 9600 baud at 50 MHz) into validated bytes. Each byte is held in a one-entry buffer and handed downstream with a valid/ready handshake. Sits directly upstream of the switchboard's command/register-write logic (the `writeNorth` / `write` path), which consumes `rx_data`.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, system clock frequency.
- `BAUD`, 9600, line rate.
- `CLKS_PER_BIT`, CLK_HZ/BAUD (= 5208), clocks per bit period; integer division, truncated.

Ports:
- `sysclk`  in  1  system clock; one clock domain, rising edge only.
- `reset`  in  1  synchronous, active-high reset.
- `serialIn`  in  1  asynchronous UART line; idle high.
- `rx_ready`  in  1  downstream accepts `rx_data` this cycle.
- `rx_data`  out  8  last received byte.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a byte completed while the buffer was full; the new byte is dropped.

## Operation
- `serialIn` passes through a 2-FF synchronizer. Both FFs reset to 1.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- Counters: `baud_cnt` is 13 bits, wide enough for CLKS_PER_BIT-1; `bit_idx` is 3 bits.
- IDLE: when the synced line is 0, clear `baud_cnt` and go to START.
- START: at `baud_cnt` = CLKS_PER_BIT/2 - 1 (mid start bit):
  - line still 0: clear `baud_cnt`, set `bit_idx` = 0, go to DATA.
  - line 1: glitch; return to IDLE with no output.
- DATA: every CLKS_PER_BIT clocks, sample the line into shift register bit `bit_idx` (LSB first). After bit 7, go to STOP.
- STOP: sample at the next mid-bit point.
  - Line 1 and buffer free (or `rx_ready` high this cycle): load the buffer, assert `rx_valid`, go to IDLE.
  - Line 1 and buffer full with `rx_ready` low: pulse `overrun`, keep the old `rx_data`, go to IDLE.
  - Line 0: pulse `frame_err`, discard the byte, go to BREAK.
- BREAK: wait until the synced line is 1, then go to IDLE. No new start is accepted while the line is held low.
- Handshake: a transfer occurs on `rx_valid` && `rx_ready`.
  - `rx_valid` drops the following cycle unless a new byte loads in that same cycle, in which case it stays high with the new data.
  - `rx_data` is stable while `rx_valid` is high.
- `rx_ready` is ignored while `rx_valid` is low.

## Timing
- Reset values:
  - `rx_data` = 8'h00; `rx_valid`, `frame_err`, `overrun` = 0.
  - FSM in IDLE; counters 0.
- A reset asserted mid-frame aborts the frame. The partial byte is lost and a buffered unconsumed byte is cleared.
- Latency: the start-bit falling edge on `serialIn` is seen after 2 cycles (synchronizer).
  - Stop bit is sampled at CLKS_PER_BIT/2 + 9*CLKS_PER_BIT = 49476 cycles after detection.
  - `rx_valid` rises on the next edge, about 49479 cycles after the falling edge (bench tolerance ±2).
- `frame_err` and `overrun` are exactly one cycle wide and never assert in the same cycle.
- Back-to-back frames: the receiver is back in IDLE half a bit into the stop bit, so a start bit immediately after a stop bit is captured.
- Baud error from truncating 5208.33 is under 0.01 %. No fractional correction.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, STOP, BREAK).
  - `UART_CLKS_PER_BIT` default constant.
  - `UART_DATA_BITS` = 8.
- Sub-module `serial_sync`: 2-FF synchronizer, reset value 1, reused for the switchboard's other asynchronous inputs.
- The buffer, FSM and counters stay in `uart_byte_rx`.

## Test plan
- Send 0x55 (start, 1,0,1,0,1,0,1,0, stop) at 5208 clocks/bit with `rx_ready` = 0 → `rx_valid` = 1 about 49479 cycles after the edge, `rx_data` = 8'h55, held stable.
- With 0x55 buffered, pulse `rx_ready` for 1 cycle, then send 0xAA → `rx_valid` falls for one byte time, then `rx_data` = 8'hAA; `frame_err` = `overrun` = 0 throughout.
- Pull `serialIn` low for 1000 cycles, then release → no `rx_valid`, FSM back in IDLE; a following 0x55 frame is received correctly.
- Send a frame with stop bit = 0 and hold the line low 20000 cycles → `frame_err` pulses once at the stop sample, no `rx_valid`, FSM stays in BREAK until the line goes high; then 0xAA is received.
- With `rx_ready` = 0, send 0x55 then 0x08 back to back → `overrun` pulses once at the second stop sample, `rx_data` stays 8'h55.
- Assert `reset` for 1 cycle mid-way through the DATA bits of a frame → all outputs 0 the next cycle; that frame yields no byte; the next full 0xAA frame gives `rx_data` = 8'hAA.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Imported by the receiver and anything that decodes its state.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int UART_CLKS_PER_BIT = 50_000_000 / 9600;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CNT_W        = 13;

endpackage

// File: rtl/serial_sync.sv
// Two-flop synchronizer for asynchronous inputs that idle high.
// Both stages reset to 1 so a reset never looks like a start bit.
module serial_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (srst) begin
                    meta_reg[gi] <= 1'b1;
                    sync_reg[gi] <= 1'b1;
                end else begin
                    meta_reg[gi] <= async_in[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign sync_out = sync_reg;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with a one-entry output buffer and valid/ready handoff.
// Samples each bit at mid-period, timed from the detected start edge.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic                      serialIn,
    input  logic                      rx_ready,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam logic [UART_CNT_W-1:0] BIT_LAST  = UART_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [UART_CNT_W-1:0] HALF_LAST = UART_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]            IDX_LAST  = 3'(UART_DATA_BITS - 1);

    logic line;

    serial_sync #(.WIDTH(1)) u_sync (
        .clk      (sysclk),
        .srst     (reset),
        .async_in (serialIn),
        .sync_out (line)
    );

    rx_state_t                 state_reg, state_next;
    logic [UART_CNT_W-1:0]     baud_cnt_reg, baud_cnt_next;
    logic [2:0]                bit_idx_reg, bit_idx_next;
    logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
    logic [UART_DATA_BITS-1:0] data_reg, data_next;
    logic                      valid_reg, valid_next;
    logic                      frame_err_reg, frame_err_next;
    logic                      overrun_reg, overrun_next;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg     <= IDLE;
            baud_cnt_reg  <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            baud_cnt_reg  <= baud_cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        baud_cnt_next  = baud_cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        valid_next     = valid_reg;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;

        // A completed transfer frees the buffer; a same-cycle load below re-arms it.
        if (valid_reg && rx_ready) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (!line) begin
                    baud_cnt_next = '0;
                    state_next    = START;
                end
            end
            START: begin
                if (baud_cnt_reg == HALF_LAST) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = line ? IDLE : DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt_reg == BIT_LAST) begin
                    baud_cnt_next          = '0;
                    shift_next[bit_idx_reg] = line;
                    if (bit_idx_reg == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt_reg == BIT_LAST) begin
                    baud_cnt_next = '0;
                    if (line) begin
                        state_next = IDLE;
                        if (!valid_reg || rx_ready) begin
                            data_next  = shift_reg;
                            valid_next = 1'b1;
                        end else begin
                            overrun_next = 1'b1;
                        end
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = BREAK;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            BREAK: begin
                if (line) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx_data   = data_reg;
    assign rx_valid  = valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at a shortened bit period.
// Expected bytes are queued as frames are sent and popped when consumed.
module tb_uart_byte_rx;

    localparam int CPB     = 16;
    localparam int LAT_NOM = CPB / 2 + 9 * CPB + 3;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       serialIn;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    uart_byte_rx #(
        .CLK_HZ (CPB * 10),
        .BAUD   (10)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .serialIn  (serialIn),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 sysclk = ~sysclk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int fe_cnt = 0, ov_cnt = 0, rise_cnt = 0, last_rise = 0;
    int start_cyc = 0;
    logic [7:0] exp_q[$];

    always @(posedge sysclk) cyc <= cyc + 1;

    // Passive monitor: pulse counts, pulse shape, data stability.
    logic prev_valid = 1'b0, prev_xfer = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge sysclk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
            prev_fe    = 1'b0;
            prev_ov    = 1'b0;
        end else begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_valid && !prev_valid) begin
                rise_cnt++;
                last_rise = cyc;
            end
            if (frame_err || overrun) begin
                n_vec++;
                assert (!(frame_err && overrun) && !(frame_err && prev_fe) && !(overrun && prev_ov))
                else begin
                    n_err++;
                    $error("FAIL pulse_shape: fe=%0b ov=%0b prev_fe=%0b prev_ov=%0b, want single exclusive pulses",
                           frame_err, overrun, prev_fe, prev_ov);
                end
            end
            if (prev_valid && rx_valid && !prev_xfer) begin
                n_vec++;
                assert (rx_data === prev_data)
                else begin
                    n_err++;
                    $error("FAIL data_stable: got %h want %h", rx_data, prev_data);
                end
            end
            prev_valid = rx_valid;
            prev_xfer  = rx_valid && rx_ready;
            prev_fe    = frame_err;
            prev_ov    = overrun;
            prev_data  = rx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        start_cyc = cyc;
        serialIn = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            serialIn = d[i];
            wait_cycles(CPB);
        end
        serialIn = stop_bit;
        wait_cycles(CPB);
    endtask

    task automatic check_latency(input string tag);
        int lat;
        lat = last_rise - start_cyc;
        n_vec++;
        assert (lat >= LAT_NOM - 2 && lat <= LAT_NOM + 2)
        else begin
            n_err++;
            $error("FAIL %s: got %0d cycles want %0d +/-2", tag, lat, LAT_NOM);
        end
    endtask

    task automatic check_byte(input string tag);
        logic [7:0] exp;
        exp = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
        check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp});
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check("consume_drop", {31'd0, rx_valid}, 32'd0);
    endtask

    initial begin
        int rc, fc, oc;
        reset    = 1'b1;
        serialIn = 1'b1;
        rx_ready = 1'b0;
        wait_cycles(3);
        reset = 1'b0;
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_fe", {31'd0, frame_err}, 32'd0);
        check("rst_ov", {31'd0, overrun}, 32'd0);
        wait_cycles(4);

        // 0x55 with no consumer, then held
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        check_latency("lat_55");
        check_byte("b55");
        wait_cycles(3 * CPB);
        check_byte("b55_hold");

        // consume, then 0xAA
        consume();
        exp_q.push_back(8'hAA);
        send_frame(8'hAA, 1'b1);
        check_latency("lat_aa");
        check_byte("baa");
        check("fe_none", fe_cnt, 0);
        check("ov_none", ov_cnt, 0);
        consume();

        // short low glitch is rejected
        rc = rise_cnt;
        serialIn = 1'b0;
        wait_cycles(4);
        serialIn = 1'b1;
        wait_cycles(2 * CPB);
        check("glitch_rise", rise_cnt, rc);
        check("glitch_valid", {31'd0, rx_valid}, 32'd0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        check_byte("post_glitch");
        consume();

        // framing error followed by a held-low break
        rc = rise_cnt;
        fc = fe_cnt;
        send_frame(8'hC3, 1'b0);
        wait_cycles(60);
        serialIn = 1'b1;
        wait_cycles(12 * CPB);
        check("break_fe", fe_cnt, fc + 1);
        check("break_rise", rise_cnt, rc);
        check("break_valid", {31'd0, rx_valid}, 32'd0);
        exp_q.push_back(8'hAA);
        send_frame(8'hAA, 1'b1);
        check_latency("lat_post_break");
        check_byte("post_break");
        consume();

        // overrun: second byte dropped while buffer is full
        oc = ov_cnt;
        fc = fe_cnt;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        send_frame(8'h08, 1'b1);
        wait_cycles(CPB);
        check("ovr_cnt", ov_cnt, oc + 1);
        check("ovr_fe", fe_cnt, fc);
        check_byte("ovr_keep");

        // reset mid-data clears the buffered byte and aborts the frame (0xF0)
        serialIn = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            serialIn = 1'b0;
            wait_cycles(CPB);
        end
        serialIn = 1'b1;
        wait_cycles(CPB / 2);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        exp_q.delete();
        check("mid_rst_data", {24'd0, rx_data}, 32'd0);
        check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("mid_rst_fe", {31'd0, frame_err}, 32'd0);
        check("mid_rst_ov", {31'd0, overrun}, 32'd0);
        rc = rise_cnt;
        wait_cycles(8 * CPB);
        check("mid_rst_rise", rise_cnt, rc);
        exp_q.push_back(8'hAA);
        send_frame(8'hAA, 1'b1);
        check_latency("lat_post_rst");
        check_byte("post_rst");
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
